// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode and controller state encodings for the cpu_run_ctrl host sequencer.
package cpu_ctrl_pkg;

  localparam logic [2:0] OP_WR_IMEM = 3'b000;
  localparam logic [2:0] OP_WR_DMEM = 3'b001;
  localparam logic [2:0] OP_RD_IMEM = 3'b010;
  localparam logic [2:0] OP_RD_DMEM = 3'b011;
  localparam logic [2:0] OP_RUN     = 3'b100;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR       = 3'd1;
  localparam logic [2:0] S_RD_ISSUE = 3'd2;
  localparam logic [2:0] S_RD_CAP   = 3'd3;
  localparam logic [2:0] S_RUN      = 3'd4;
  localparam logic [2:0] S_RSP      = 3'd5;

endpackage

// File: rtl/cpu_run_ctrl_counter.sv
// Saturating executed-cycle counter with a captured length and a last-cycle compare.
module run_cycle_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             clr,
  input  logic [CNT_W-1:0] len,
  input  logic             inc,
  output logic [CNT_W-1:0] count_nxt,
  output logic             done
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] len_q;

  assign count_nxt = (count == '1) ? count : count + CNT_W'(1);
  // done marks the current enabled cycle as the last one the budget allows
  assign done = inc && (count_nxt == len_q);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      count <= '0;
      len_q <= '0;
    end else if (clr) begin
      count <= '0;
      len_q <= len;
    end else if (inc) begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Host-side sequencer: turns commands into imem/dmem port strobes and bounded core enable windows.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned ADDR_W = 64
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [63:0]       cmd_wdata,
  input  logic [CNT_W-1:0]  cmd_len,
  input  logic              stop_req,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [63:0]       rsp_data,
  output logic              rsp_err,
  output logic              enable,
  output logic [ADDR_W-1:0] addr_ext,
  output logic              wen_ext,
  output logic              ren_ext,
  output logic [31:0]       wdata_ext,
  input  logic [31:0]       rdata_ext,
  output logic [ADDR_W-1:0] addr_ext_2,
  output logic              wen_ext_2,
  output logic              ren_ext_2,
  output logic [63:0]       wdata_ext_2,
  input  logic [63:0]       rdata_ext_2,
  output logic              busy
);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic             ready_en;
  logic             rd_dmem;
  logic             accept;
  logic             run_start;
  logic [CNT_W-1:0] count_nxt;
  logic             run_done;

  // ready_en keeps cmd_ready low while reset is asserted even though state is IDLE
  assign cmd_ready = ready_en && (state == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign run_start = accept && (cmd_op == OP_RUN);

  run_cycle_counter #(.CNT_W(CNT_W)) u_counter (
    .clk       (clk),
    .arst_n    (arst_n),
    .clr       (run_start),
    .len       (cmd_len),
    .inc       (enable),
    .count_nxt (count_nxt),
    .done      (run_done)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_WR_IMEM, OP_WR_DMEM: state_nxt = S_WR;
            OP_RD_IMEM, OP_RD_DMEM: state_nxt = S_RD_ISSUE;
            OP_RUN:                 state_nxt = (cmd_len == '0) ? S_RSP : S_RUN;
            default:                state_nxt = S_RSP;
          endcase
        end
      end
      S_WR:       state_nxt = S_IDLE;
      S_RD_ISSUE: state_nxt = S_RD_CAP;
      S_RD_CAP:   state_nxt = S_RSP;
      S_RUN:      if (stop_req || run_done) state_nxt = S_RSP;
      S_RSP:      if (rsp_valid && rsp_ready) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= S_IDLE;
      ready_en    <= 1'b0;
      busy        <= 1'b0;
      rd_dmem     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      enable      <= 1'b0;
      addr_ext    <= '0;
      wen_ext     <= 1'b0;
      ren_ext     <= 1'b0;
      wdata_ext   <= '0;
      addr_ext_2  <= '0;
      wen_ext_2   <= 1'b0;
      ren_ext_2   <= 1'b0;
      wdata_ext_2 <= '0;
    end else begin
      state     <= state_nxt;
      ready_en  <= 1'b1;
      busy      <= (state_nxt != S_IDLE);
      wen_ext   <= 1'b0;
      ren_ext   <= 1'b0;
      wen_ext_2 <= 1'b0;
      ren_ext_2 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (cmd_op)
              OP_WR_IMEM: begin
                wen_ext   <= 1'b1;
                addr_ext  <= cmd_addr;
                wdata_ext <= cmd_wdata[31:0];
              end
              OP_WR_DMEM: begin
                wen_ext_2   <= 1'b1;
                addr_ext_2  <= cmd_addr;
                wdata_ext_2 <= cmd_wdata;
              end
              OP_RD_IMEM: begin
                ren_ext  <= 1'b1;
                addr_ext <= cmd_addr;
                rd_dmem  <= 1'b0;
              end
              OP_RD_DMEM: begin
                ren_ext_2  <= 1'b1;
                addr_ext_2 <= cmd_addr;
                rd_dmem    <= 1'b1;
              end
              OP_RUN: begin
                if (cmd_len == '0) begin
                  rsp_valid <= 1'b1;
                  rsp_data  <= '0;
                end else begin
                  enable <= 1'b1;
                end
              end
              default: begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
                rsp_data  <= '0;
              end
            endcase
          end
        end
        S_RD_CAP: begin
          rsp_valid <= 1'b1;
          rsp_data  <= rd_dmem ? rdata_ext_2 : {32'd0, rdata_ext};
        end
        S_RUN: begin
          if (stop_req || run_done) begin
            enable    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_data  <= 64'(count_nxt);
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl with behavioural imem/dmem and a minimal core stand-in.
module tb_cpu_run_ctrl;

  localparam logic [31:0] INSN_ADDI = 32'h00500093;
  localparam logic [31:0] INSN_SD   = 32'h00103023;

  typedef struct packed {
    logic        err;
    logic [63:0] data;
  } rsp_t;

  logic        clk;
  logic        arst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [63:0] cmd_addr;
  logic [63:0] cmd_wdata;
  logic [31:0] cmd_len;
  logic        stop_req;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_err;
  logic        enable;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [31:0] rdata_ext;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [63:0] wdata_ext_2;
  logic [63:0] rdata_ext_2;
  logic        busy;

  logic [31:0] imem [16];
  logic [63:0] dmem [16];
  int unsigned core_cyc;

  rsp_t sb[$];
  int unsigned checks;
  int unsigned failures;
  int unsigned en_cycles;
  int unsigned strobes;
  int unsigned viol;
  int unsigned unexp;

  cpu_run_ctrl #(.CNT_W(32), .ADDR_W(64)) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_len     (cmd_len),
    .stop_req    (stop_req),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .enable      (enable),
    .addr_ext    (addr_ext),
    .wen_ext     (wen_ext),
    .ren_ext     (ren_ext),
    .wdata_ext   (wdata_ext),
    .rdata_ext   (rdata_ext),
    .addr_ext_2  (addr_ext_2),
    .wen_ext_2   (wen_ext_2),
    .ren_ext_2   (ren_ext_2),
    .wdata_ext_2 (wdata_ext_2),
    .rdata_ext_2 (rdata_ext_2),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memories with one-cycle read latency; the core stand-in retires "sd x1,0(x0)" on its 6th enabled cycle.
  always @(posedge clk) begin
    if (wen_ext) imem[addr_ext[5:2]] <= wdata_ext;
    if (ren_ext) rdata_ext <= imem[addr_ext[5:2]];
    if (wen_ext_2) dmem[addr_ext_2[6:3]] <= wdata_ext_2;
    if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[6:3]];
    if (enable) begin
      core_cyc <= core_cyc + 1;
      if (core_cyc == 5 && imem[1] == INSN_SD)
        dmem[0] <= {{52{imem[0][31]}}, imem[0][31:20]};
    end else begin
      core_cyc <= 0;
    end
  end

  always @(negedge clk) begin
    int s;
    s = int'(wen_ext) + int'(ren_ext) + int'(wen_ext_2) + int'(ren_ext_2);
    if (enable) en_cycles++;
    strobes += s;
    if (s > 1 || (enable && s != 0)) viol++;
    if (arst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        unexp++;
      end else begin
        rsp_t e;
        e = sb.pop_front();
        check("rsp_data", rsp_data, e.data);
        check("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
      end
    end
  end

  task automatic do_cmd(input logic [2:0] op, input logic [63:0] addr,
                        input logic [63:0] wd, input logic [31:0] len);
    int unsigned n;
    @(posedge clk); #1;
    cmd_op = op; cmd_addr = addr; cmd_wdata = wd; cmd_len = len;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic push_rsp(input logic err, input logic [63:0] data);
    rsp_t e;
    e.err = err;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    int unsigned n;
    n = 0;
    while ((busy || rsp_valid || sb.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("done_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0; failures = 0; en_cycles = 0; strobes = 0; viol = 0; unexp = 0;
    for (int i = 0; i < 16; i++) begin
      imem[i] = '0;
      dmem[i] = '0;
    end
    arst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0;
    cmd_len = '0; stop_req = 1'b0; rsp_ready = 1'b1; rdata_ext = '0; rdata_ext_2 = '0;

    // reset values
    @(negedge clk);
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_outs", {59'd0, enable, rsp_valid, rsp_err, wen_ext, wen_ext_2}, 64'd0);
    check("rst_rsp_data", rsp_data, 64'd0);
    @(posedge clk); #1;
    arst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    // WR_DMEM then RD_DMEM
    do_cmd(OP_WR_DMEM_C(), 64'h10, 64'hDEADBEEF_CAFEF00D, 0);
    @(negedge clk);
    check("wr_dmem_wen", {63'd0, wen_ext_2}, 64'd1);
    check("wr_dmem_addr", addr_ext_2, 64'h10);
    check("wr_dmem_data", wdata_ext_2, 64'hDEADBEEF_CAFEF00D);
    @(negedge clk);
    check("wr_dmem_wen_off", {63'd0, wen_ext_2}, 64'd0);
    check("wr_idle_ready", {63'd0, cmd_ready}, 64'd1);
    check("wr_addr_hold", addr_ext_2, 64'h10);

    push_rsp(1'b0, 64'hDEADBEEF_CAFEF00D);
    do_cmd(3'b011, 64'h10, 64'd0, 0);
    @(negedge clk);
    check("rd_dmem_ren", {63'd0, ren_ext_2}, 64'd1);
    @(negedge clk);
    check("rd_t2_no_rsp", {63'd0, rsp_valid}, 64'd0);
    @(negedge clk);
    check("rd_t3_rsp", {63'd0, rsp_valid}, 64'd1);
    wait_done();

    // instruction memory round trip
    do_cmd(3'b000, 64'h4, {32'd0, INSN_ADDI}, 0);
    @(negedge clk);
    check("wr_imem_wen", {63'd0, wen_ext}, 64'd1);
    check("wr_imem_data", {32'd0, wdata_ext}, {32'd0, INSN_ADDI});
    check("wr_imem_addr", addr_ext, 64'h4);
    wait_done();
    push_rsp(1'b0, 64'h0000_0000_0050_0093);
    do_cmd(3'b010, 64'h4, 64'd0, 0);
    wait_done();

    // full run: program addi x1,x0,5 ; sd x1,0(x0)
    do_cmd(3'b000, 64'h0, {32'd0, INSN_ADDI}, 0);
    do_cmd(3'b000, 64'h4, {32'd0, INSN_SD}, 0);
    wait_done();
    en_cycles = 0;
    push_rsp(1'b0, 64'd20);
    do_cmd(3'b100, 64'd0, 64'd0, 32'd20);
    wait_done();
    check("run20_enable_cycles", 64'(en_cycles), 64'd20);
    push_rsp(1'b0, 64'd5);
    do_cmd(3'b011, 64'h0, 64'd0, 0);
    wait_done();

    // early stop in the 7th enabled cycle
    en_cycles = 0;
    push_rsp(1'b0, 64'd7);
    do_cmd(3'b100, 64'd0, 64'd0, 32'd100);
    repeat (6) begin @(posedge clk); #1; end
    stop_req = 1'b1;
    @(posedge clk); #1;
    stop_req = 1'b0;
    @(negedge clk);
    check("stop_enable_low", {63'd0, enable}, 64'd0);
    wait_done();
    check("stop_enable_cycles", 64'(en_cycles), 64'd7);

    // stop coinciding with the final budgeted cycle
    en_cycles = 0;
    push_rsp(1'b0, 64'd4);
    do_cmd(3'b100, 64'd0, 64'd0, 32'd4);
    repeat (3) begin @(posedge clk); #1; end
    stop_req = 1'b1;
    @(posedge clk); #1;
    stop_req = 1'b0;
    wait_done();
    check("stop_last_cycles", 64'(en_cycles), 64'd4);

    // stop in the accept cycle is ignored
    en_cycles = 0;
    push_rsp(1'b0, 64'd3);
    stop_req = 1'b1;
    do_cmd(3'b100, 64'd0, 64'd0, 32'd3);
    stop_req = 1'b0;
    wait_done();
    check("stop_at_t_cycles", 64'(en_cycles), 64'd3);

    // zero-length run
    en_cycles = 0;
    push_rsp(1'b0, 64'd0);
    do_cmd(3'b100, 64'd0, 64'd0, 32'd0);
    @(negedge clk);
    check("len0_rsp_t1", {63'd0, rsp_valid}, 64'd1);
    wait_done();
    check("len0_enable_cycles", 64'(en_cycles), 64'd0);

    // illegal opcode
    strobes = 0;
    en_cycles = 0;
    push_rsp(1'b1, 64'd0);
    do_cmd(3'b111, 64'h8, 64'h1234, 32'd5);
    wait_done();
    check("illegal_strobes", 64'(strobes), 64'd0);
    check("illegal_enable", 64'(en_cycles), 64'd0);

    // response held under backpressure
    rsp_ready = 1'b0;
    push_rsp(1'b0, 64'hDEADBEEF_CAFEF00D);
    do_cmd(3'b011, 64'h10, 64'd0, 0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {63'd0, rsp_valid}, 64'd1);
      check("stall_data", rsp_data, 64'hDEADBEEF_CAFEF00D);
      check("stall_cmd_ready", {63'd0, cmd_ready}, 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_done();

    // reset in enabled cycle 3 abandons the run
    do_cmd(3'b100, 64'd0, 64'd0, 32'd50);
    repeat (2) begin @(posedge clk); #1; end
    #2;
    arst_n = 1'b0;
    #1;
    check("rst_mid_enable", {63'd0, enable}, 64'd0);
    check("rst_mid_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    arst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    repeat (10) @(negedge clk);
    check("rst_mid_no_rsp", {63'd0, rsp_valid}, 64'd0);

    check("excl_violations", 64'(viol), 64'd0);
    check("unexpected_rsp", 64'(unexp), 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic [2:0] OP_WR_DMEM_C();
    return 3'b001;
  endfunction

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
